// File: rtl/csr_execute_unit_if.sv
// Issue, CSR-file read and result-side signals of csr_execute_unit.
// slave is the execute unit; master is whoever drives issue and consumes results.
interface csr_execute_unit_if #(
    parameter int ROB_ID_WIDTH = 5
);
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [2:0]              issue_op;
    logic [11:0]             issue_csr_addr;
    logic [31:0]             issue_rs1_value;
    logic [4:0]              issue_imm;
    logic                    issue_rs1_zero;
    logic                    issue_rd_valid;
    logic [ROB_ID_WIDTH-1:0] issue_rob_id;
    logic [11:0]             csr_raddr;
    logic [31:0]             csr_rdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [ROB_ID_WIDTH-1:0] out_rob_id;
    logic [31:0]             out_rd_value;
    logic                    out_csr_wen;
    logic [11:0]             out_csr_waddr;
    logic [31:0]             out_csr_wdata;
    logic                    out_illegal;

    modport slave (
        input  flush, issue_valid, issue_op, issue_csr_addr, issue_rs1_value, issue_imm,
               issue_rs1_zero, issue_rd_valid, issue_rob_id, csr_rdata, out_ready,
        output issue_ready, csr_raddr, out_valid, out_rob_id, out_rd_value, out_csr_wen,
               out_csr_waddr, out_csr_wdata, out_illegal
    );

    modport master (
        output flush, issue_valid, issue_op, issue_csr_addr, issue_rs1_value, issue_imm,
               issue_rs1_zero, issue_rd_valid, issue_rob_id, csr_rdata, out_ready,
        input  issue_ready, csr_raddr, out_valid, out_rob_id, out_rd_value, out_csr_wen,
               out_csr_waddr, out_csr_wdata, out_illegal
    );
endinterface

// File: rtl/csr_execute_unit.sv
// CSR instruction execute unit: one op in flight, IDLE -> READ (2 cycles) -> OUT.
// Define CSR_EXECUTE_STAT_EN to add the saturating illegal_count output.
module csr_access_check #(
    parameter bit WRITE_PREMISSION = 1'b0
) (
    input  logic [11:0] addr_i,
    output logic        ok_o
);
    logic implemented;

    always_comb begin
        case (addr_i)
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hF11, 12'hF12, 12'hF13, 12'hF14: implemented = 1'b1;
            default:                            implemented = 1'b0;
        endcase
    end

    // addr[11:10]==11 marks the read-only CSR space
    assign ok_o = implemented && (!WRITE_PREMISSION || (addr_i[11:10] != 2'b11));
endmodule

module csr_execute_unit #(
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    csr_execute_unit_if.slave   io
`ifdef CSR_EXECUTE_STAT_EN
    ,
    output logic [15:0]         illegal_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT} state_t;

    state_t                  state_q;
    logic                    rd_phase_q;
    logic [2:0]              op_q;
    logic [11:0]             addr_q;
    logic [31:0]             rs1_q;
    logic [4:0]              imm_q;
    logic                    rs1z_q;
    logic                    rdv_q;
    logic [ROB_ID_WIDTH-1:0] rob_q;

    logic                    issue_ready_q, out_valid_q, out_wen_q, out_ill_q;
    logic [ROB_ID_WIDTH-1:0] out_rob_q;
    logic [31:0]             out_rd_q, out_wdata_q;
    logic [11:0]             out_waddr_q;

    logic        read_ok, write_ok;
    logic        is_rw, is_rs, is_rc, do_read, do_write, src_zero, illegal;
    logic [31:0] operand, old_val, new_val;

    csr_access_check #(.WRITE_PREMISSION(1'b0)) u_rd_chk (.addr_i(addr_q), .ok_o(read_ok));
    csr_access_check #(.WRITE_PREMISSION(1'b1)) u_wr_chk (.addr_i(addr_q), .ok_o(write_ok));

    assign old_val  = io.csr_rdata;
    assign is_rw    = (op_q[1:0] == 2'b01);
    assign is_rs    = (op_q[1:0] == 2'b10);
    assign is_rc    = (op_q[1:0] == 2'b11);
    assign operand  = op_q[2] ? {27'd0, imm_q} : rs1_q;
    assign src_zero = op_q[2] ? (imm_q == 5'd0) : rs1z_q;
    assign do_read  = !is_rw || rdv_q;
    assign do_write = is_rw || !src_zero;
    // funct3 000/100 are not CSR ops; report them as illegal rather than guessing
    assign illegal  = !(is_rw || is_rs || is_rc) ||
                      (do_read && !read_ok) || (do_write && !write_ok);

    always_comb begin
        new_val = old_val & ~operand;
        if (is_rw)      new_val = operand;
        else if (is_rs) new_val = old_val | operand;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            rd_phase_q    <= 1'b0;
            op_q          <= '0;
            addr_q        <= '0;
            rs1_q         <= '0;
            imm_q         <= '0;
            rs1z_q        <= 1'b0;
            rdv_q         <= 1'b0;
            rob_q         <= '0;
            issue_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
            out_wen_q     <= 1'b0;
            out_ill_q     <= 1'b0;
            out_rob_q     <= '0;
            out_rd_q      <= '0;
            out_wdata_q   <= '0;
            out_waddr_q   <= '0;
        end else if (io.flush) begin
            state_q       <= S_IDLE;
            rd_phase_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            out_valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (io.issue_valid) begin
                    op_q          <= io.issue_op;
                    addr_q        <= io.issue_csr_addr;
                    rs1_q         <= io.issue_rs1_value;
                    imm_q         <= io.issue_imm;
                    rs1z_q        <= io.issue_rs1_zero;
                    rdv_q         <= io.issue_rd_valid;
                    rob_q         <= io.issue_rob_id;
                    rd_phase_q    <= 1'b0;
                    issue_ready_q <= 1'b0;
                    state_q       <= S_READ;
                end
                // first READ cycle presents the address, the second has csr_rdata
                S_READ: if (!rd_phase_q) begin
                    rd_phase_q <= 1'b1;
                end else begin
                    state_q     <= S_OUT;
                    out_valid_q <= 1'b1;
                    out_rob_q   <= rob_q;
                    out_waddr_q <= addr_q;
                    out_wdata_q <= new_val;
                    out_ill_q   <= illegal;
                    out_wen_q   <= !illegal && do_write;
                    out_rd_q    <= (!illegal && do_read) ? old_val : 32'd0;
                end
                S_OUT: if (io.out_ready) begin
                    state_q       <= S_IDLE;
                    out_valid_q   <= 1'b0;
                    issue_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CSR_EXECUTE_STAT_EN
    logic [15:0] illegal_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_count_q <= '0;
        else if (!io.flush && state_q == S_OUT && io.out_ready && out_ill_q &&
                 illegal_count_q != 16'hFFFF)
            illegal_count_q <= illegal_count_q + 16'd1;
    end

    assign illegal_count = illegal_count_q;
`endif

    assign io.issue_ready   = issue_ready_q;
    assign io.csr_raddr     = addr_q;
    assign io.out_valid     = out_valid_q;
    assign io.out_rob_id    = out_rob_q;
    assign io.out_rd_value  = out_rd_q;
    assign io.out_csr_wen   = out_wen_q;
    assign io.out_csr_waddr = out_waddr_q;
    assign io.out_csr_wdata = out_wdata_q;
    assign io.out_illegal   = out_ill_q;
endmodule

// File: tb/tb_csr_execute_unit.sv
// Self-checking bench for csr_execute_unit: directed cases plus random ops
// against a reference model and a synchronous CSR-file model.
module tb_csr_execute_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_execute_unit_if #(.ROB_ID_WIDTH(5)) io();

`ifdef CSR_EXECUTE_STAT_EN
    logic [15:0] illegal_count;
    csr_execute_unit #(.ROB_ID_WIDTH(5)) dut (.clk(clk), .rst(rst), .io(io), .illegal_count(illegal_count));
`else
    csr_execute_unit #(.ROB_ID_WIDTH(5)) dut (.clk(clk), .rst(rst), .io(io));
`endif

    // CSR file: registered read, data valid the cycle after the address
    logic [31:0] mem [4096];
    always @(posedge clk) io.csr_rdata <= mem[io.csr_raddr];

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    logic [11:0] impl_tab [13] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
    logic [2:0]  op_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit csr_exists(input logic [11:0] a);
        foreach (impl_tab[i]) if (impl_tab[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // Architectural meaning of a CSR instruction, straight from the ISA rules
    task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] imm, input bit rs1z, input bit rdv, input logic [31:0] old,
                         output logic [31:0] rd, output bit wen, output logic [31:0] wdata, output bit ill);
        bit writes_always = (op == 3'd1) || (op == 3'd5);
        bit uses_imm      = (op >= 3'd5);
        logic [31:0] src  = uses_imm ? 32'(imm) : rs1;
        bit reads  = !writes_always || rdv;
        bit writes = writes_always || (uses_imm ? (imm != 0) : !rs1z);
        bool_check: begin
            bit readable = csr_exists(a);
            bit writable = readable && (a < 12'hC00);
            ill = (reads && !readable) || (writes && !writable);
        end
        case (op)
            3'd1, 3'd5: wdata = src;
            3'd2, 3'd6: wdata = old | src;
            default:    wdata = old & ~src;
        endcase
        wen = !ill && writes;
        rd  = (!ill && reads) ? old : 32'd0;
    endtask

    task automatic clear_inputs();
        io.flush = 0; io.issue_valid = 0; io.issue_op = 0; io.issue_csr_addr = 0;
        io.issue_rs1_value = 0; io.issue_imm = 0; io.issue_rs1_zero = 0;
        io.issue_rd_valid = 0; io.issue_rob_id = 0; io.out_ready = 0;
    endtask

    task automatic reset_dut();
        rst = 0;
        clear_inputs();
        step(); step();
        rst = 1;
        exp_cnt = 0;
        step();
    endtask

    // flush_at: 0 none, 1 during READ, 2 in OUT after the hold cycles
    task automatic do_op(input string nm, input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] rs1, input logic [4:0] imm, input bit rs1z, input bit rdv,
                         input logic [31:0] old, input logic [4:0] rob, input int hold, input int flush_at);
        logic [31:0] e_rd, e_wd;
        bit e_wen, e_ill;
        int n = 0;
        mem[a] = old;
        model(op, a, rs1, imm, rs1z, rdv, old, e_rd, e_wen, e_wd, e_ill);
        while (!io.issue_ready && n < 20) begin step(); n++; end
        if (n == 20) check({nm, "_ready_timeout"}, 32'(io.issue_ready), 32'd1);
        io.issue_valid = 1; io.issue_op = op; io.issue_csr_addr = a; io.issue_rs1_value = rs1;
        io.issue_imm = imm; io.issue_rs1_zero = rs1z; io.issue_rd_valid = rdv; io.issue_rob_id = rob;
        step();                                   // accept edge N
        io.issue_valid = 0; io.issue_csr_addr = 12'($urandom); io.issue_rs1_value = $urandom;
        io.issue_imm = 5'($urandom); io.issue_op = 3'($urandom);
        check({nm, "_busy"}, 32'(io.issue_ready), 32'd0);
        check({nm, "_raddr"}, 32'(io.csr_raddr), 32'(a));
        if (flush_at == 1) begin
            io.flush = 1; step(); io.flush = 0;
            check({nm, "_flushR_valid"}, 32'(io.out_valid), 32'd0);
            check({nm, "_flushR_ready"}, 32'(io.issue_ready), 32'd1);
            step(); step();
            check({nm, "_flushR_nout"}, 32'(io.out_valid), 32'd0);
            return;
        end
        step();                                   // N+1
        check({nm, "_n1_valid"}, 32'(io.out_valid), 32'd0);
        step();                                   // N+2
        for (int h = 0; h <= hold; h++) begin
            check({nm, "_valid"}, 32'(io.out_valid), 32'd1);
            check({nm, "_rob"},   32'(io.out_rob_id), 32'(rob));
            check({nm, "_rd"},    io.out_rd_value, e_rd);
            check({nm, "_wen"},   32'(io.out_csr_wen), 32'(e_wen));
            check({nm, "_ill"},   32'(io.out_illegal), 32'(e_ill));
            if (e_wen) begin
                check({nm, "_waddr"}, 32'(io.out_csr_waddr), 32'(a));
                check({nm, "_wdata"}, io.out_csr_wdata, e_wd);
            end
            if (h > 0) check({nm, "_hold_busy"}, 32'(io.issue_ready), 32'd0);
            if (h < hold) step();
        end
        if (flush_at == 2) begin
            io.flush = 1; io.out_ready = $urandom_range(0, 1); step(); io.flush = 0; io.out_ready = 0;
            check({nm, "_flushO_valid"}, 32'(io.out_valid), 32'd0);
            check({nm, "_flushO_ready"}, 32'(io.issue_ready), 32'd1);
        end else begin
            io.out_ready = 1; step(); io.out_ready = 0;
            if (e_ill && exp_cnt < 16'hFFFF) exp_cnt++;
            check({nm, "_done_valid"}, 32'(io.out_valid), 32'd0);
            check({nm, "_done_ready"}, 32'(io.issue_ready), 32'd1);
        end
`ifdef CSR_EXECUTE_STAT_EN
        check({nm, "_cnt"}, 32'(illegal_count), 32'(exp_cnt));
`endif
    endtask

    initial begin
        clear_inputs();
        foreach (mem[i]) mem[i] = 32'd0;
        step();
        // reset values while reset is held
        check("rst_ready", 32'(io.issue_ready), 32'd1);
        check("rst_valid", 32'(io.out_valid), 32'd0);
        check("rst_wen",   32'(io.out_csr_wen), 32'd0);
        check("rst_ill",   32'(io.out_illegal), 32'd0);
        check("rst_rd",    io.out_rd_value, 32'd0);
        check("rst_wdata", io.out_csr_wdata, 32'd0);
        check("rst_waddr", 32'(io.out_csr_waddr), 32'd0);
        check("rst_rob",   32'(io.out_rob_id), 32'd0);
`ifdef CSR_EXECUTE_STAT_EN
        check("rst_cnt",   32'(illegal_count), 32'd0);
`endif
        rst = 1;
        step();

        do_op("rs_mscratch", 3'd2, 12'h340, 32'd0, 5'd0, 1'b1, 1'b1, 32'h1234, 5'd3, 0, 0);
        do_op("rc_mstatus",  3'd3, 12'h300, 32'h8, 5'd0, 1'b0, 1'b1, 32'h1888, 5'd4, 0, 0);
        do_op("rwi_vendor",  3'd5, 12'hF11, 32'd0, 5'd3, 1'b0, 1'b1, 32'hABCD, 5'd5, 0, 0);
        do_op("rs_hartid",   3'd2, 12'hF14, 32'd0, 5'd0, 1'b1, 1'b1, 32'd0,    5'd6, 0, 0);
        do_op("rw_nord",     3'd1, 12'h305, 32'hCAFE0000, 5'd0, 1'b0, 1'b0, 32'h77, 5'd7, 0, 0);
        do_op("hold_flush",  3'd6, 12'h344, 32'd0, 5'd9, 1'b0, 1'b1, 32'h5, 5'd8, 5, 2);
        do_op("read_flush",  3'd1, 12'h341, 32'h11, 5'd0, 1'b0, 1'b1, 32'h22, 5'd9, 0, 1);

        // flush together with issue_valid in IDLE must not accept
        io.issue_valid = 1; io.issue_op = 3'd2; io.issue_csr_addr = 12'h340; io.flush = 1;
        step();
        io.issue_valid = 0; io.flush = 0;
        check("idle_flush_ready", 32'(io.issue_ready), 32'd1);
        step(); step();
        check("idle_flush_nout", 32'(io.out_valid), 32'd0);

        // asynchronous reset mid-operation
        io.issue_valid = 1; io.issue_op = 3'd1; io.issue_csr_addr = 12'h340; io.issue_rd_valid = 1;
        step();
        io.issue_valid = 0;
        step();
        #2 rst = 0;
        #1;
        check("async_rst_ready", 32'(io.issue_ready), 32'd1);
        check("async_rst_valid", 32'(io.out_valid), 32'd0);
        step();
        rst = 1;
        exp_cnt = 0;
        step(); step();
        check("async_rst_nout", 32'(io.out_valid), 32'd0);

        for (int k = 0; k < 40; k++) begin
            int sel = $urandom_range(0, 15);
            logic [11:0] a;
            int fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (sel < 13)       a = impl_tab[sel];
            else if (sel == 13) a = 12'h7FF;
            else if (sel == 14) a = 12'h000;
            else                a = 12'($urandom);
            do_op("rnd", op_tab[$urandom_range(0, 5)], a, $urandom, 5'($urandom),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), $urandom,
                  5'($urandom), $urandom_range(0, 2), fl);
        end

`ifdef CSR_EXECUTE_STAT_EN
        reset_dut();
        for (int k = 0; k < 3; k++)
            do_op("stat", 3'd1, 12'h7FF, $urandom, 5'd0, 1'b0, 1'b1, 32'd0, 5'(k), 0, 0);
        check("stat_three", 32'(illegal_count), 32'd3);
        force dut.illegal_count_q = 16'hFFFF;
        step();
        release dut.illegal_count_q;
        exp_cnt = 16'hFFFF;
        do_op("stat_sat", 3'd2, 12'h7FF, 32'd1, 5'd0, 1'b0, 1'b1, 32'd0, 5'd1, 0, 0);
        check("stat_sat_final", 32'(illegal_count), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end
endmodule
